// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch stage: owns PC/NPC, runs a req/ack read to
// instruction memory, captures the word into IR and flags a fetch timeout.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned PC_STEP     = 4,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        readim,
  input  logic        ldpc,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] irout,
  output logic [31:0] npc,
  output logic [31:0] pc,
  output logic        ir_valid,
  output logic        fetch_busy,
  output logic        fetch_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] npc_reg, npc_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] ir_reg, ir_next;
  logic        ir_valid_reg, ir_valid_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic        pend_ldpc_reg, pend_ldpc_next;
  logic        pend_branch_reg, pend_branch_next;
  logic [31:0] pend_target_reg, pend_target_next;

  // Working values for PC selection
  logic [31:0] idle_target;
  logic        eff_ldpc;
  logic        eff_branch;
  logic [31:0] eff_target;
  logic [31:0] fetch_npc;
  logic [31:0] req_target;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    npc_next         = npc_reg;
    addr_next        = addr_reg;
    ir_next          = ir_reg;
    ir_valid_next    = 1'b0;
    cnt_next         = cnt_reg;
    pend_ldpc_next   = pend_ldpc_reg;
    pend_branch_next = pend_branch_reg;
    pend_target_next = pend_target_reg;

    idle_target = branch ? branch_target : npc_reg;
    idle_target = {idle_target[31:2], 2'b00};

    // A ldpc arriving in the ack cycle itself supersedes any earlier pending one
    eff_ldpc   = ldpc | pend_ldpc_reg;
    eff_branch = ldpc ? branch : pend_branch_reg;
    eff_target = ldpc ? branch_target : pend_target_reg;
    fetch_npc  = addr_reg + 32'(PC_STEP);
    req_target = eff_branch ? eff_target : fetch_npc;
    req_target = {req_target[31:2], 2'b00};

    unique case (state_reg)
      S_IDLE: begin
        if (ldpc) begin
          pc_next = idle_target;
        end
        if (readim) begin
          state_next     = S_REQ;
          addr_next      = ldpc ? idle_target : pc_reg;
          cnt_next       = '0;
          pend_ldpc_next = 1'b0;
        end
      end
      S_REQ: begin
        if (ldpc) begin
          pend_ldpc_next   = 1'b1;
          pend_branch_next = branch;
          pend_target_next = branch_target;
        end
        if (imem_ack) begin
          ir_next        = imem_rdata;
          npc_next       = fetch_npc;
          ir_valid_next  = 1'b1;
          state_next     = S_IDLE;
          pend_ldpc_next = 1'b0;
          if (eff_ldpc) begin
            pc_next = req_target;
          end
        end else if (cnt_reg == CNT_LAST) begin
          state_next     = S_ERR;
          pend_ldpc_next = 1'b0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_ERR: begin
        state_next = S_ERR;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg          <= RESET_PC;
      npc_reg         <= RESET_PC;
      addr_reg        <= RESET_PC;
      ir_reg          <= '0;
      ir_valid_reg    <= 1'b0;
      cnt_reg         <= '0;
      pend_ldpc_reg   <= 1'b0;
      pend_branch_reg <= 1'b0;
      pend_target_reg <= '0;
    end else begin
      pc_reg          <= pc_next;
      npc_reg         <= npc_next;
      addr_reg        <= addr_next;
      ir_reg          <= ir_next;
      ir_valid_reg    <= ir_valid_next;
      cnt_reg         <= cnt_next;
      pend_ldpc_reg   <= pend_ldpc_next;
      pend_branch_reg <= pend_branch_next;
      pend_target_reg <= pend_target_next;
    end
  end

  // Status outputs are decodes of the registered state only
  assign imem_req   = (state_reg == S_REQ);
  assign fetch_busy = (state_reg == S_REQ);
  assign fetch_err  = (state_reg == S_ERR);
  assign imem_addr  = addr_reg;
  assign irout      = ir_reg;
  assign npc        = npc_reg;
  assign pc         = pc_reg;
  assign ir_valid   = ir_valid_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: expected fetches are queued by the
// stimulus and checked by an independent monitor when the DUT presents them.
module tb_instr_fetch_unit;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        readim = 1'b0;
  logic        ldpc = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] irout;
  logic [31:0] npc;
  logic [31:0] pc;
  logic        ir_valid;
  logic        fetch_busy;
  logic        fetch_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] addr_q[$];
  logic [63:0] fetch_q[$];

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .PC_STEP    (4),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .readim       (readim),
    .ldpc         (ldpc),
    .branch       (branch),
    .branch_target(branch_target),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .irout        (irout),
    .npc          (npc),
    .pc           (pc),
    .ir_valid     (ir_valid),
    .fetch_busy   (fetch_busy),
    .fetch_err    (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: address checked when an ack is offered, IR/NPC on ir_valid
  initial begin : monitor
    logic        prev_irv;
    logic [31:0] ea;
    logic [63:0] ef;
    prev_irv = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (imem_req && imem_ack) begin
          if (addr_q.size() == 0) begin
            check32("unexpected_req_ack", imem_addr, 32'hxxxx_xxxx);
          end else begin
            ea = addr_q.pop_front();
            check32("imem_addr_at_ack", imem_addr, ea);
          end
        end
        if (ir_valid) begin
          check32("ir_valid_single_pulse", {31'd0, prev_irv}, 32'd0);
          if (fetch_q.size() == 0) begin
            check32("unexpected_ir_valid", irout, 32'hxxxx_xxxx);
          end else begin
            ef = fetch_q.pop_front();
            check32("irout", irout, ef[63:32]);
            check32("npc", npc, ef[31:0]);
          end
        end
        prev_irv = ir_valid;
      end else begin
        prev_irv = 1'b0;
      end
    end
  end

  task automatic fetch(input int waits, input logic [31:0] rdata,
                       input logic [31:0] exp_addr, input logic [31:0] exp_npc);
    addr_q.push_back(exp_addr);
    fetch_q.push_back({rdata, exp_npc});
    readim = 1'b1;
    cyc();
    readim = 1'b0;
    check32("req_and_busy", {30'd0, imem_req, fetch_busy}, 32'd3);
    repeat (waits) cyc();
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    cyc();
    imem_ack   = 1'b0;
    imem_rdata = '0;
    cyc();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // Reset state, sampled while reset is held
    cyc();
    cyc();
    check32("rst_pc", pc, 32'h0);
    check32("rst_npc", npc, 32'h0);
    check32("rst_irout", irout, 32'h0);
    check32("rst_flags", {28'd0, imem_req, ir_valid, fetch_busy, fetch_err}, 32'd0);
    reset = 1'b1;
    cyc();

    // T1: readim at c0, ack at c2
    fetch(1, 32'h4000_0005, 32'h0, 32'h4);
    check32("t1_pc_unchanged", pc, 32'h0);

    // T2: sequential then branch PC updates in IDLE
    ldpc = 1'b1; branch = 1'b0;
    cyc();
    ldpc = 1'b0;
    check32("t2_pc_seq", pc, 32'h4);
    ldpc = 1'b1; branch = 1'b1; branch_target = 32'h0000_0103;
    cyc();
    ldpc = 1'b0; branch = 1'b0;
    check32("t2_pc_branch_aligned", pc, 32'h0000_0100);

    // T3: ldpc during REQ is deferred until after ack; readim in REQ ignored
    addr_q.push_back(32'h100);
    fetch_q.push_back({32'h1234_5678, 32'h104});
    readim = 1'b1;
    cyc();
    readim = 1'b0;
    ldpc = 1'b1; branch = 1'b1; branch_target = 32'h80;
    cyc();
    ldpc = 1'b0; branch = 1'b0;
    check32("t3_pc_held_in_req", pc, 32'h100);
    check32("t3_addr_held", imem_addr, 32'h100);
    readim = 1'b1;
    cyc();
    readim = 1'b0;
    cyc();
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    cyc();
    imem_ack = 1'b0; imem_rdata = '0;
    check32("t3_pc_after_ack", pc, 32'h80);
    cyc();
    check32("t3_back_idle", {31'd0, imem_req}, 32'd0);

    // readim and ldpc in the same IDLE cycle: fetch uses the new pc
    addr_q.push_back(32'h200);
    fetch_q.push_back({32'hAAAA_5555, 32'h204});
    readim = 1'b1; ldpc = 1'b1; branch = 1'b1; branch_target = 32'h201;
    cyc();
    readim = 1'b0; ldpc = 1'b0; branch = 1'b0;
    check32("same_cycle_pc", pc, 32'h200);
    check32("same_cycle_addr", imem_addr, 32'h200);
    imem_ack = 1'b1; imem_rdata = 32'hAAAA_5555;
    cyc();
    imem_ack = 1'b0; imem_rdata = '0;
    cyc();

    // T5a: npc wraps around 2^32
    ldpc = 1'b1; branch = 1'b1; branch_target = 32'hFFFF_FFFF;
    cyc();
    ldpc = 1'b0; branch = 1'b0;
    check32("t5_pc_top", pc, 32'hFFFF_FFFC);
    fetch(0, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 32'h0);
    ldpc = 1'b1;
    cyc();
    ldpc = 1'b0;
    check32("t5_pc_wrapped", pc, 32'h0);

    // T5b: ack in the timeout cycle wins
    fetch(TO - 1, 32'h0BAD_F00D, 32'h0, 32'h4);
    check32("t5_ack_wins_no_err", {31'd0, fetch_err}, 32'd0);

    // T4: timeout
    readim = 1'b1;
    cyc();
    readim = 1'b0;
    repeat (TO - 1) cyc();
    check32("t4_not_yet_err", {30'd0, imem_req, fetch_err}, 32'd2);
    cyc();
    check32("t4_err_flags", {29'd0, imem_req, fetch_busy, fetch_err}, 32'd1);
    readim = 1'b1; ldpc = 1'b1; branch = 1'b1; branch_target = 32'h400;
    imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA;
    repeat (3) cyc();
    readim = 1'b0; ldpc = 1'b0; branch = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    check32("t4_err_sticky", {29'd0, imem_req, fetch_busy, fetch_err}, 32'd1);
    check32("t4_pc_ignored", pc, 32'h0);
    check32("t4_irout_kept", irout, 32'h0BAD_F00D);

    // T6: reset asserted mid-REQ acts immediately
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    ldpc = 1'b1; branch = 1'b1; branch_target = 32'h300;
    cyc();
    ldpc = 1'b0; branch = 1'b0;
    check32("t6_pc_before", pc, 32'h300);
    readim = 1'b1;
    cyc();
    readim = 1'b0;
    cyc();
    check32("t6_in_req", {31'd0, imem_req}, 32'd1);
    reset = 1'b0;
    #1;
    check32("t6_async_flags", {28'd0, imem_req, ir_valid, fetch_busy, fetch_err}, 32'd0);
    check32("t6_async_pc", pc, 32'h0);
    check32("t6_async_irout", irout, 32'h0);
    check32("t6_async_addr", imem_addr, 32'h0);
    cyc();
    reset = 1'b1;
    cyc();
    fetch(2, 32'h1111_2222, 32'h0, 32'h4);

    repeat (2) cyc();
    check32("addr_q_drained", 32'(addr_q.size()), 32'd0);
    check32("fetch_q_drained", 32'(fetch_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
